encode42_ser: RTL and testbench

ENCODE42_SER -- requirements
Module: encode42_ser

---
 rtl/encode42_pkg.sv | 19 +
 rtl/encode42_ser_prio_enc4.sv | 25 ++
 rtl/encode42_ser.sv | 83 ++++++++
 tb/tb_encode42_ser.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/encode42_pkg.sv
// Shared types and widths for the 4-to-2 serialising priority encoder.
package encode42_pkg;

  localparam int IN_W  = 4;
  localparam int OUT_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic logic [IN_W-1:0] onehot(input logic [OUT_W-1:0] idx);
    logic [IN_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/encode42_ser_prio_enc4.sv
// Combinational priority encoder: highest set bit index, single-bit flag, non-empty flag.
module prio_enc4
  import encode42_pkg::*;
(
  input  logic [IN_W-1:0]  mask,
  output logic [OUT_W-1:0] index,
  output logic             last,
  output logic             any
);

  always_comb begin
    index = '0;
    casez (mask)
      4'b1???: index = 2'd3;
      4'b01??: index = 2'd2;
      4'b001?: index = 2'd1;
      default: index = 2'd0;
    endcase
  end

  assign any  = |mask;
  // Exactly one bit set: non-empty and clearing the lowest set bit leaves nothing.
  assign last = any && ((mask & (mask - 1'b1)) == '0);

endmodule

// File: rtl/encode42_ser.sv
// Accepts a 4-bit request vector and emits the set indices one per handshake, highest first.
// Optional err pulse on a dropped (empty/disabled) vector when ENCODE42_ERR_EN is defined.
//
// state | meaning
// IDLE  | ready for a vector; empty or disabled vectors are dropped
// EMIT  | presenting highest pending index; bit cleared on each handshake
module encode42_ser
  import encode42_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  input  logic [IN_W-1:0]  in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_y,
  output logic             out_last,
  output logic             err
);

  state_t          state;
  logic [IN_W-1:0] mask;
  logic [OUT_W-1:0] enc_idx;
  logic            enc_last;
  logic            enc_any;
  logic            accept;
  logic            load;

  prio_enc4 u_enc (
    .mask  (mask),
    .index (enc_idx),
    .last  (enc_last),
    .any   (enc_any)
  );

  assign accept = in_valid && (state == IDLE);
  assign load   = accept && en && (in_x != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            mask  <= in_x;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            mask <= mask & ~onehot(enc_idx);
            // An empty mask cannot be presented; fall back to IDLE if it ever is.
            if (enc_last || !enc_any) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign out_y     = enc_idx;
  assign out_last  = enc_last && (state == EMIT);

`ifdef ENCODE42_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= accept && !load;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_encode42_ser.sv
// Scoreboard bench for encode42_ser: directed scenarios followed by randomized traffic.
module tb_encode42_ser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       en = 1'b0;
  logic [3:0] in_x = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_y;
  logic       out_last;
  logic       err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int idx;
    int last;
  } exp_t;

  exp_t exp_q[$];
  logic exp_err = 1'b0;
  logic prev_acc = 1'b0;
  logic prev_en = 1'b0;
  logic [3:0] prev_x = 4'd0;

  encode42_ser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .en        (en),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_last  (out_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a vector becomes its set indices in descending order, last on the lowest.
  task automatic model_edge();
    int lowest;
    logic is_drop;
    is_drop = 1'b0;
    if (prev_acc) begin
      if (prev_en && prev_x != 4'd0) begin
        lowest = 0;
        for (int i = 0; i < 4; i++) if (prev_x[i]) begin lowest = i; break; end
        for (int i = 3; i >= 0; i--)
          if (prev_x[i]) exp_q.push_back('{idx: i, last: (i == lowest) ? 1 : 0});
      end else begin
        is_drop = 1'b1;
      end
    end
`ifdef ENCODE42_ERR_EN
    exp_err = is_drop;
`else
    exp_err = 1'b0;
`endif
    prev_acc = 1'b0;
  endtask

  task automatic drive(input logic v, input logic e, input logic [3:0] x, input logic r);
    @(posedge clk);
    model_edge();
    #1;
    in_valid  = v;
    en        = e;
    in_x      = x;
    out_ready = r;
    prev_acc  = v && in_ready;
    prev_en   = e;
    prev_x    = x;
  endtask

  task automatic do_reset();
    @(posedge clk);
    model_edge();
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    prev_acc = 1'b0;
    exp_err  = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_y", out_y, 0);
    check("rst_err", err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: expected state follows the scoreboard; every presented index is compared to its head.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", out_valid, (exp_q.size() != 0) ? 1 : 0);
      check("in_ready", in_ready, (exp_q.size() == 0) ? 1 : 0);
      check("err", err, exp_err);
      if (out_valid && exp_q.size() != 0) begin
        check("out_y", out_y, exp_q[0].idx);
        check("out_last", out_last, exp_q[0].last);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_y", out_y, 0);
    check("reset_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1010 with ready high
    drive(1, 1, 4'b1010, 1);
    repeat (4) drive(0, 1, 4'b0000, 1);

    // 1111 stalled three cycles
    drive(1, 1, 4'b1111, 0);
    repeat (3) drive(0, 1, 4'b0000, 0);
    repeat (5) drive(0, 1, 4'b0000, 1);

    // empty and disabled vectors are dropped
    drive(1, 1, 4'b0000, 1);
    drive(0, 1, 4'b0000, 1);
    drive(1, 0, 4'b0100, 1);
    repeat (2) drive(0, 1, 4'b0000, 1);

    // back-to-back with in_valid held
    drive(1, 1, 4'b0001, 1);
    drive(1, 1, 4'b1000, 1);
    drive(1, 1, 4'b1000, 1);
    drive(1, 1, 4'b1000, 1);
    repeat (3) drive(0, 1, 4'b0000, 1);

    // reset mid-emit of 0111 after its first index
    drive(1, 1, 4'b0111, 1);
    drive(0, 1, 4'b0000, 1);
    do_reset();
    repeat (3) drive(0, 1, 4'b0000, 1);

    // inputs toggled during emit must not disturb the sequence
    drive(1, 1, 4'b1101, 0);
    drive(1, 1, 4'b0010, 0);
    drive(1, 0, 4'b1111, 1);
    drive(1, 1, 4'b0001, 0);
    repeat (5) drive(0, 1, 4'b0110, 1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0);
      if (n == 300) do_reset();
    end

    for (int n = 0; n < 40 && exp_q.size() != 0; n++) drive(0, 1, 4'b0000, 1);
    drive(0, 1, 4'b0000, 1);
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
